// File: rtl/mode_seq_pkg.sv
// rtl/mode_seq_pkg.sv - state encoding, mode codes and mode_params field layout for mode_sequencer
package mode_seq_pkg;

  typedef enum logic [1:0] {
    S_MANUAL  = 2'd0,
    S_PENDING = 2'd1,
    S_AUTO    = 2'd2
  } state_e;

  localparam logic [2:0] MODE_PASS = 3'd0;
  localparam logic [2:0] MODE_RAMP = 3'd1;
  localparam logic [2:0] MODE_BARS = 3'd2;
  localparam logic [2:0] MODE_XORS = 3'd3;

  localparam int TIMING_BIT = 7;
  localparam int MODE_MSB   = 6;
  localparam int MODE_LSB   = 4;
  localparam int ARGS_MSB   = 3;
  localparam int ARGS_LSB   = 0;

  // Out-of-range modes (>= num_modes) fold back to 0 along with the normal wrap.
  function automatic logic [2:0] next_mode(input logic [2:0] m, input int num_modes);
    if (int'(m) >= num_modes - 1) begin
      return 3'd0;
    end
    return m + 3'd1;
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// rtl/mode_sequencer_if.sv - config request handshake between controller and mode_sequencer
interface mode_sequencer_if;
  logic [7:0] cfg_in;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_in, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_in, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/frame_divider.sv
// rtl/frame_divider.sv - counts frame_end pulses and fires step once every dwell+1 frames
module frame_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       clear,
  input  logic [7:0] dwell,
  output logic       step
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // >= rather than == so a dwell lowered below the current count steps at once.
  assign step = frame_end && !clear && (count_q >= dwell);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (frame_end) begin
      count_d = step ? 8'd0 : count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - applies requested pattern modes on frame boundaries, optional auto cycling
// Auto cycling (S_AUTO and the frame divider) is built only with MODE_SEQ_AUTO_EN defined.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PARAMS = 8'h10,
  parameter int         NUM_MODES    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_end,
  mode_sequencer_if.slave   cfg,
  input  logic              auto_en,
  input  logic [7:0]        dwell,
  output logic [7:0]        mode_params,
  output logic              pending,
  output logic              advance
);

  state_e     state_q, state_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] shadow_q, shadow_d;
  logic       advance_q, advance_d;
  logic       accept;
  logic       auto_req;
  logic       div_step;

  assign cfg.cfg_ready = (state_q != S_PENDING);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign mode_params   = mode_q;
  assign pending       = (state_q == S_PENDING);
  assign advance       = advance_q;

`ifdef MODE_SEQ_AUTO_EN
  logic div_clear;
  logic div_tick;

  // An accept on the frame_end cycle takes precedence, so the counter must hold.
  assign div_clear = (state_q != S_AUTO) || !auto_en;
  assign div_tick  = frame_end && !accept;
  assign auto_req  = auto_en;

  frame_divider u_frame_divider (
    .clk       (clk),
    .reset     (reset),
    .frame_end (div_tick),
    .clear     (div_clear),
    .dwell     (dwell),
    .step      (div_step)
  );
`else
  logic unused_auto;

  assign auto_req    = 1'b0;
  assign div_step    = 1'b0;
  assign unused_auto = auto_en ^ (^dwell);
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    shadow_d  = shadow_q;
    advance_d = 1'b0;
    case (state_q)
      S_MANUAL: begin
        if (accept) begin
          shadow_d = cfg.cfg_in;
          state_d  = S_PENDING;
        end else if (auto_req) begin
          state_d = S_AUTO;
        end
      end
      S_PENDING: begin
        if (frame_end) begin
          mode_d    = shadow_q;
          advance_d = 1'b1;
          state_d   = auto_req ? S_AUTO : S_MANUAL;
        end
      end
      S_AUTO: begin
        if (accept) begin
          shadow_d = cfg.cfg_in;
          state_d  = S_PENDING;
        end else if (!auto_req) begin
          state_d = S_MANUAL;
        end else if (div_step) begin
          mode_d[MODE_MSB:MODE_LSB] = next_mode(mode_q[MODE_MSB:MODE_LSB], NUM_MODES);
          advance_d                 = 1'b1;
        end
      end
      default: begin
        state_d = S_MANUAL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_MANUAL;
      mode_q    <= RESET_PARAMS;
      shadow_q  <= 8'd0;
      advance_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      shadow_q  <= shadow_d;
      advance_q <= advance_d;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - directed self-checking bench for mode_sequencer (auto tests need MODE_SEQ_AUTO_EN)
module tb_mode_sequencer;

  logic       clk;
  logic       reset;
  logic       frame_end;
  logic       auto_en;
  logic [7:0] dwell;
  logic [7:0] mode_params;
  logic       pending;
  logic       advance;

  int n_pass;
  int n_total;
  int adv_cnt;

  mode_sequencer_if cfg_if ();

  mode_sequencer #(
    .RESET_PARAMS (8'h10),
    .NUM_MODES    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_end   (frame_end),
    .cfg         (cfg_if.slave),
    .auto_en     (auto_en),
    .dwell       (dwell),
    .mode_params (mode_params),
    .pending     (pending),
    .advance     (advance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic send_cfg(input logic [7:0] v);
    cfg_if.cfg_in    = v;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    n_pass           = 0;
    n_total          = 0;
    reset            = 1'b1;
    frame_end        = 1'b0;
    auto_en          = 1'b0;
    dwell            = 8'd0;
    cfg_if.cfg_in    = 8'h00;
    cfg_if.cfg_valid = 1'b0;

    tick();
    tick();
    check("rst_mode", mode_params, 8'h10);
    check("rst_ready", cfg_if.cfg_ready, 1'b1);
    check("rst_pending", pending, 1'b0);
    check("rst_advance", advance, 1'b0);
    reset = 1'b0;
    tick();
    check("rel_mode", mode_params, 8'h10);
    check("rel_ready", cfg_if.cfg_ready, 1'b1);

    // Mid-frame accept, applied only after frame_end.
    send_cfg(8'h31);
    check("acc_pending", pending, 1'b1);
    check("acc_ready", cfg_if.cfg_ready, 1'b0);
    check("acc_mode_hold", mode_params, 8'h10);
    tick();
    tick();
    check("mid_frame_hold", mode_params, 8'h10);
    check("mid_frame_adv", advance, 1'b0);
    frame();
    check("apply_mode", mode_params, 8'h31);
    check("apply_adv", advance, 1'b1);
    check("apply_pending", pending, 1'b0);
    tick();
    check("apply_adv_once", advance, 1'b0);

    // Accept coincident with frame_end in manual: no apply until the next frame_end.
    frame_end = 1'b1;
    send_cfg(8'h22);
    frame_end = 1'b0;
    check("coinc_m_mode", mode_params, 8'h31);
    check("coinc_m_pending", pending, 1'b1);
    check("coinc_m_adv", advance, 1'b0);
    tick();
    frame();
    check("coinc_m_apply", mode_params, 8'h22);

    // Reset while pending discards the shadow.
    tick();
    send_cfg(8'h45);
    check("rp_pending", pending, 1'b1);
    reset = 1'b1;
    #1;
    check("rp_async_mode", mode_params, 8'h10);
    check("rp_async_pending", pending, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    frame();
    check("rp_no_apply", mode_params, 8'h10);
    check("rp_no_adv", advance, 1'b0);
    tick();

`ifdef MODE_SEQ_AUTO_EN
    send_cfg(8'h2C);
    frame();
    check("auto_seed", mode_params, 8'h2C);
    auto_en = 1'b1;
    dwell   = 8'd2;
    tick();
    for (int f = 1; f <= 12; f++) begin
      frame();
      case (f)
        3:  check("auto_f3", mode_params, 8'h3C);
        6:  check("auto_f6", mode_params, 8'h0C);
        9:  check("auto_f9", mode_params, 8'h1C);
        12: check("auto_f12", mode_params, 8'h2C);
        default: check("auto_noadv", advance, 1'b0);
      endcase
      tick();
    end

    // Counter at 2 == dwell, but the coincident accept suppresses the step.
    frame();
    tick();
    frame();
    tick();
    frame_end = 1'b1;
    send_cfg(8'h5A);
    frame_end = 1'b0;
    check("coinc_a_mode", mode_params, 8'h2C);
    check("coinc_a_adv", advance, 1'b0);
    check("coinc_a_pending", pending, 1'b1);
    tick();
    frame();
    check("coinc_a_apply", mode_params, 8'h5A);
    check("coinc_a_apply_adv", advance, 1'b1);
    tick();
    frame();
    tick();
    frame();
    check("oor_hold", mode_params, 8'h5A);
    tick();
    frame();
    check("oor_wrap", mode_params, 8'h0A);
    tick();

    dwell = 8'd0;
    frame();
    check("dwell0_a", mode_params, 8'h1A);
    tick();
    frame();
    check("dwell0_b", mode_params, 8'h2A);
    tick();

    auto_en = 1'b0;
    tick();
    frame();
    check("auto_off_mode", mode_params, 8'h2A);
    check("auto_off_adv", advance, 1'b0);
    tick();

    auto_en = 1'b1;
    dwell   = 8'd255;
    tick();
    adv_cnt = 0;
    for (int f = 0; f < 255; f++) begin
      frame();
      if (advance) adv_cnt++;
    end
    check("d255_noadv", adv_cnt, 0);
    check("d255_hold", mode_params, 8'h2A);
    frame();
    check("d255_step", mode_params, 8'h3A);
    check("d255_adv", advance, 1'b1);
`else
    auto_en = 1'b1;
    dwell   = 8'd0;
    tick();
    adv_cnt = 0;
    for (int f = 0; f < 10; f++) begin
      frame();
      if (advance) adv_cnt++;
      tick();
    end
    check("noauto_mode", mode_params, 8'h10);
    check("noauto_adv_cnt", adv_cnt, 0);
    check("noauto_ready", cfg_if.cfg_ready, 1'b1);
    send_cfg(8'h33);
    frame();
    check("noauto_apply", mode_params, 8'h33);
    tick();
    frame();
    check("noauto_after_mode", mode_params, 8'h33);
    check("noauto_after_adv", advance, 1'b0);
    check("noauto_after_ready", cfg_if.cfg_ready, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
